// File: rtl/aes_pkg.sv
// AES S-box constants and lookup helper.
// Shared by the substitution datapath.
package aes_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_STG   = 3;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(
    input logic [7:0] b,
    input logic       inv
  );
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Dual-mode byte substitution.
// Purely combinational forward/inverse S-box.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              inv_i,
  output logic [BYTE_W-1:0] sub_o
);

  assign sub_o = sbox_lookup(byte_i, inv_i);

endmodule

// File: rtl/aes_sbox_pipe.sv
// Pipelined multi-lane SubBytes / InvSubBytes unit.
// Valid/ready chain with bubble collapsing and flush.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES       = 16,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inv,
  input  logic [LANES*BYTE_W-1:0] in_data,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BYTE_W-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int unsigned DW = LANES * BYTE_W;

  if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES out of range");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_STG) begin : g_bad_stg
    $error("aes_sbox_pipe: PIPE_STAGES out of range");
  end

  logic [DW-1:0] lut;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_byte u_byte (
      .byte_i (in_data[BYTE_W*i +: BYTE_W]),
      .inv_i  (in_inv),
      .sub_o  (lut[BYTE_W*i +: BYTE_W])
    );
  end

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] vld_d;
  logic [PIPE_STAGES-1:0] en;
  logic [DW-1:0]          data_q [PIPE_STAGES];
  logic [DW-1:0]          data_d [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];

  // Enable ripples back from the output: a stage advances if it
  // is empty or its successor takes its beat this cycle.
  always_comb begin
    logic nxt;
    en  = '0;
    nxt = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      en[k] = !vld_q[k] || nxt;
      nxt   = en[k];
    end
  end

  assign in_ready = !flush && en[0];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_d[k]  = in_valid && in_ready;
      assign data_d[k] = lut;
      assign tag_d[k]  = in_tag;
    end else begin : g_body
      assign vld_d[k]  = vld_q[k-1];
      assign data_d[k] = data_q[k-1];
      assign tag_d[k]  = tag_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (flush) begin
          vld_q[k] <= 1'b0;
        end else if (en[k]) begin
          vld_q[k] <= vld_d[k];
        end
        // Payload only moves with a real beat; bubbles leave it as is.
        if (en[k] && vld_d[k]) begin
          data_q[k] <= data_d[k];
          tag_q[k]  <= tag_d[k];
        end
      end
    end
  end

  assign out_valid = vld_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe.
// Three instances: 2 stages x 16 lanes, 1 and 3 stages x 4 lanes.
module tb_aes_sbox_pipe;

  logic clk;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst, a_flush, a_in_valid, a_in_ready, a_in_inv;
  logic [127:0] a_in_data, a_out_data;
  logic [3:0]   a_in_tag, a_out_tag;
  logic         a_out_valid, a_out_ready;

  logic         b_rst, b_flush, b_in_valid, b_in_ready, b_in_inv;
  logic [31:0]  b_in_data, b_out_data;
  logic [3:0]   b_in_tag, b_out_tag;
  logic         b_out_valid, b_out_ready;

  logic         c_rst, c_flush, c_in_valid, c_in_ready, c_in_inv;
  logic [31:0]  c_in_data, c_out_data;
  logic [3:0]   c_in_tag, c_out_tag;
  logic         c_out_valid, c_out_ready;

  aes_sbox_pipe #(.LANES(16), .PIPE_STAGES(2), .TAG_W(4)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag)
  );

  aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(1), .TAG_W(4)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(3), .TAG_W(4)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_inv(c_in_inv), .in_data(c_in_data), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_tag(c_out_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input logic v, input logic inv,
                         input logic [127:0] d, input logic [3:0] t);
    a_in_valid = v;
    a_in_inv   = inv;
    a_in_data  = d;
    a_in_tag   = t;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a_rst = 1; a_flush = 0; a_in_valid = 0; a_in_inv = 0;
    a_in_data = '0; a_in_tag = '0; a_out_ready = 1;
    b_rst = 1; b_flush = 0; b_in_valid = 0; b_in_inv = 0;
    b_in_data = '0; b_in_tag = '0; b_out_ready = 1;
    c_rst = 1; c_flush = 0; c_in_valid = 0; c_in_inv = 0;
    c_in_data = '0; c_in_tag = '0; c_out_ready = 1;
    tick();
    tick();
    a_rst = 0; b_rst = 0; c_rst = 0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_in_ready", a_in_ready, 1);

    // forward and inverse beats, then interleaved directions
    a_drive(1, 0, '0, 4'h3);
    chk("fwd0_in_ready", a_in_ready, 1);
    tick();
    a_drive(1, 0, {{15{8'h00}}, 8'h53}, 4'h4);
    chk("lat_not_yet", a_out_valid, 0);
    tick();
    chk("fwd0_valid", a_out_valid, 1);
    chk("fwd0_data", a_out_data, {16{8'h63}});
    chk("fwd0_tag", a_out_tag, 4'h3);
    a_drive(1, 1, {{12{8'h00}}, 8'hED, 8'h0A, 8'h63, 8'h00}, 4'h5);
    tick();
    chk("fwd53_data", a_out_data, {{15{8'h63}}, 8'hED});
    chk("fwd53_tag", a_out_tag, 4'h4);
    a_drive(1, 0, {16{8'h01}}, 4'h1);
    tick();
    chk("inv_data", a_out_data,
        {{12{8'h52}}, 8'h53, 8'hA3, 8'h00, 8'h52});
    chk("inv_tag", a_out_tag, 4'h5);
    a_drive(1, 1, {16{8'h7C}}, 4'h2);
    tick();
    chk("il0_valid", a_out_valid, 1);
    chk("il0_data", a_out_data, {16{8'h7C}});
    chk("il0_tag", a_out_tag, 4'h1);
    a_drive(1, 0, {16{8'hFF}}, 4'h6);
    tick();
    a_drive(0, 0, '0, 4'h0);
    chk("il1_valid", a_out_valid, 1);
    chk("il1_data", a_out_data, {16{8'h01}});
    chk("il1_tag", a_out_tag, 4'h2);
    tick();
    chk("il2_valid", a_out_valid, 1);
    chk("il2_data", a_out_data, {16{8'h16}});
    chk("il2_tag", a_out_tag, 4'h6);
    tick();
    chk("drain_empty", a_out_valid, 0);

    // backpressure: capacity 2, third beat waits for out_ready
    a_out_ready = 0;
    a_drive(1, 0, {16{8'h10}}, 4'h7);
    chk("bp_acc0", a_in_ready, 1);
    tick();
    a_drive(1, 0, {16{8'h20}}, 4'h8);
    chk("bp_acc1", a_in_ready, 1);
    tick();
    a_drive(1, 0, {16{8'h30}}, 4'h9);
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_in_ready", a_in_ready, 0);
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_hold_data", a_out_data, {16{8'hCA}});
      chk("bp_hold_tag", a_out_tag, 4'h7);
      tick();
    end
    a_out_ready = 1;
    #1;
    chk("bp_acc2", a_in_ready, 1);
    chk("bp_out0", a_out_data, {16{8'hCA}});
    tick();
    a_drive(0, 0, '0, 4'h0);
    chk("bp_out1_data", a_out_data, {16{8'hB7}});
    chk("bp_out1_tag", a_out_tag, 4'h8);
    tick();
    chk("bp_out2_data", a_out_data, {16{8'h04}});
    chk("bp_out2_tag", a_out_tag, 4'h9);
    tick();
    chk("bp_empty", a_out_valid, 0);

    // flush with two beats in flight
    a_out_ready = 0;
    a_drive(1, 0, {16{8'h40}}, 4'hA);
    tick();
    a_drive(1, 0, {16{8'h50}}, 4'hB);
    tick();
    a_flush = 1;
    a_drive(1, 0, {16{8'h60}}, 4'hD);
    chk("fl_in_ready", a_in_ready, 0);
    tick();
    a_flush = 0;
    a_drive(0, 0, '0, 4'h0);
    chk("fl_out_valid", a_out_valid, 0);
    a_out_ready = 1;
    a_drive(1, 0, {16{8'h70}}, 4'hC);
    chk("fl_post_in_ready", a_in_ready, 1);
    tick();
    a_drive(0, 0, '0, 4'h0);
    chk("fl_post_lat", a_out_valid, 0);
    tick();
    chk("fl_post_valid", a_out_valid, 1);
    chk("fl_post_data", a_out_data, {16{8'h51}});
    chk("fl_post_tag", a_out_tag, 4'hC);
    tick();
    chk("fl_no_ghost", a_out_valid, 0);

    // reset mid-stream
    a_drive(1, 1, {16{8'h00}}, 4'hE);
    tick();
    a_drive(1, 0, {16{8'h11}}, 4'hF);
    tick();
    a_rst = 1;
    a_drive(0, 0, '0, 4'h0);
    tick();
    a_rst = 0;
    #1;
    chk("a_mrst_valid", a_out_valid, 0);
    chk("a_mrst_data", a_out_data, 0);
    chk("a_mrst_tag", a_out_tag, 0);
    chk("a_mrst_in_ready", a_in_ready, 1);

    // one stage: visible right after the accepting edge
    b_in_valid = 1; b_in_data = 32'h0A63_0053; b_in_tag = 4'h2;
    b_in_inv = 0;
    #1;
    chk("b_in_ready", b_in_ready, 1);
    tick();
    b_in_valid = 0;
    #1;
    chk("b_lat_valid", b_out_valid, 1);
    chk("b_lat_data", b_out_data, 32'h67FB_63ED);
    chk("b_lat_tag", b_out_tag, 4'h2);
    b_out_ready = 0;
    b_in_valid = 1; b_in_inv = 1; b_in_data = 32'hED0A_6300;
    #1;
    chk("b_full_in_ready", b_in_ready, 0);
    b_rst = 1;
    tick();
    b_rst = 0; b_in_valid = 0; b_out_ready = 1;
    #1;
    chk("b_mrst_valid", b_out_valid, 0);
    chk("b_mrst_data", b_out_data, 0);
    chk("b_mrst_tag", b_out_tag, 0);
    chk("b_mrst_in_ready", b_in_ready, 1);

    // three stages: visible after the third edge
    c_in_valid = 1; c_in_inv = 1;
    c_in_data = 32'hED0A_6300; c_in_tag = 4'h5;
    tick();
    c_in_valid = 0;
    #1;
    chk("c_lat1", c_out_valid, 0);
    tick();
    chk("c_lat2", c_out_valid, 0);
    tick();
    chk("c_lat3_valid", c_out_valid, 1);
    chk("c_lat3_data", c_out_data, 32'h53A3_0052);
    chk("c_lat3_tag", c_out_tag, 4'h5);
    tick();
    c_in_valid = 1; c_in_inv = 0;
    c_in_data = 32'hFF01_0000; c_in_tag = 4'h9;
    tick();
    tick();
    c_rst = 1; c_in_valid = 0;
    tick();
    c_rst = 0;
    #1;
    chk("c_mrst_valid", c_out_valid, 0);
    chk("c_mrst_data", c_out_data, 0);
    chk("c_mrst_tag", c_out_tag, 0);
    chk("c_mrst_in_ready", c_in_ready, 1);
    tick();
    chk("c_mrst_stays_empty", c_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
